// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: active-low row drive, 2-flop column sync, frame debounce, one pulse per press.
// Latency: key_valid rises 1 cycle after the DEBOUNCE_SCANS-th matching frame completes; no backpressure (pulse is fire-and-forget).
// Optional KEY_REPEAT_EN: auto-repeat pulses while a key stays held.
module keypad_scanner #(
    parameter int SCAN_TICKS     = 12500,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int REPEAT_SCANS   = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DEBOUNCE = 2'd1;
    localparam logic [1:0] S_PRESSED  = 2'd2;
    localparam logic [1:0] S_RELEASE  = 2'd3;

    logic [3:0]    cols_s1, cols_s2;
    logic [TW-1:0] tick;
    logic [1:0]    row_idx;
    logic [1:0]    acc_cnt;
    logic [3:0]    acc_code;
    logic [1:0]    state;
    logic [3:0]    cand;
    logic [CW-1:0] cnt;

    logic [3:0] row_keys;
    logic [2:0] row_cnt;
    logic [1:0] row_col;
    logic [2:0] sum_cnt;
    logic [1:0] frame_cnt;
    logic [3:0] frame_code;
    logic       sample;
    logic       frame_done;
    logic       is_none;
    logic       is_single;

    assign rows = ~(4'b0001 << row_idx);

    // Per-row key count, saturated into a frame-wide NONE/SINGLE/MULTI tally.
    always_comb begin
        row_keys = ~cols_s2;
        row_cnt  = 3'(row_keys[0]) + 3'(row_keys[1]) + 3'(row_keys[2]) + 3'(row_keys[3]);
        row_col  = 2'd0;
        if (row_keys[3]) row_col = 2'd3;
        if (row_keys[2]) row_col = 2'd2;
        if (row_keys[1]) row_col = 2'd1;
        if (row_keys[0]) row_col = 2'd0;
        sum_cnt    = {1'b0, acc_cnt} + row_cnt;
        frame_cnt  = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
        frame_code = (row_cnt == 3'd1) ? {row_idx, row_col} : acc_code;
        sample     = (tick == TW'(SCAN_TICKS - 1));
        frame_done = sample && (row_idx == 2'd3);
        is_none    = (frame_cnt == 2'd0);
        is_single  = (frame_cnt == 2'd1);
    end

`ifdef KEY_REPEAT_EN
    localparam int RW = $clog2(2 * REPEAT_SCANS + 1);
    logic [RW-1:0] rep_cnt;
    logic          rep_first;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cols_s1   <= 4'b1111;
            cols_s2   <= 4'b1111;
            tick      <= '0;
            row_idx   <= 2'd0;
            acc_cnt   <= 2'd0;
            acc_code  <= 4'd0;
            state     <= S_IDLE;
            cand      <= 4'd0;
            cnt       <= '0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_cnt   <= '0;
            rep_first <= 1'b1;
`endif
        end else begin
            cols_s1   <= cols;
            cols_s2   <= cols_s1;
            key_valid <= 1'b0;

            if (sample) begin
                tick     <= '0;
                row_idx  <= row_idx + 2'd1;
                acc_cnt  <= frame_done ? 2'd0 : frame_cnt;
                acc_code <= frame_code;
            end else begin
                tick <= tick + 1'b1;
            end

            if (frame_done) begin
                case (state)
                    S_IDLE: begin
                        if (is_single) begin
                            cand <= frame_code;
                            if (DEBOUNCE_SCANS == 1) begin
                                key_code  <= frame_code;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                state     <= S_PRESSED;
                                cnt       <= '0;
`ifdef KEY_REPEAT_EN
                                rep_cnt   <= '0;
                                rep_first <= 1'b1;
`endif
                            end else begin
                                cnt   <= CW'(1);
                                state <= S_DEBOUNCE;
                            end
                        end
                    end
                    S_DEBOUNCE: begin
                        if (is_single && frame_code == cand) begin
                            if (cnt == CW'(DEBOUNCE_SCANS - 1)) begin
                                key_code  <= cand;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                state     <= S_PRESSED;
                                cnt       <= '0;
`ifdef KEY_REPEAT_EN
                                rep_cnt   <= '0;
                                rep_first <= 1'b1;
`endif
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else begin
                            state <= S_IDLE;
                            cnt   <= '0;
                        end
                    end
                    S_PRESSED: begin
                        if (is_none) begin
                            if (DEBOUNCE_SCANS == 1) begin
                                state    <= S_IDLE;
                                key_held <= 1'b0;
                            end else begin
                                state <= S_RELEASE;
                                cnt   <= CW'(1);
                            end
                        end else begin
`ifdef KEY_REPEAT_EN
                            // First repeat waits twice as long as the following ones.
                            if (rep_cnt == (rep_first ? RW'(2 * REPEAT_SCANS - 1) : RW'(REPEAT_SCANS - 1))) begin
                                key_valid <= 1'b1;
                                rep_cnt   <= '0;
                                rep_first <= 1'b0;
                            end else begin
                                rep_cnt <= rep_cnt + 1'b1;
                            end
`endif
                        end
                    end
                    default: begin
                        if (is_none) begin
                            if (cnt == CW'(DEBOUNCE_SCANS - 1)) begin
                                state    <= S_IDLE;
                                key_held <= 1'b0;
                                cnt      <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else begin
                            state <= S_PRESSED;
                            cnt   <= '0;
`ifdef KEY_REPEAT_EN
                            rep_cnt   <= '0;
                            rep_first <= 1'b1;
`endif
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model answers row drive with a 16-bit pressed mask; frame-level reference model.
module tb_keypad_scanner;

    localparam int ST = 4;
    localparam int DS = 3;
    localparam int RS = 2;

    logic       clk;
    logic       rst;
    logic [3:0] cols;
    logic [3:0] rows;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] pressed;
    int checks = 0;
    int errors = 0;
    int frame_no = 0;

    keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DS), .REPEAT_SCANS(RS)) dut (
        .clk(clk), .rst(rst), .cols(cols), .rows(rows),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        cols = 4'b1111;
        for (int r = 0; r < 4; r++)
            if (!rows[r]) cols = ~pressed[r*4 +: 4];
    end

    // Reference model: one step per frame, driven by the key mask seen during that frame.
    bit       m_held;
    bit       m_pulse;
    int       m_code;
    int       m_cand;
    int       m_run;
    int       m_none;
    int       m_rep;

    task automatic model_reset();
        m_held = 0; m_pulse = 0; m_code = 0; m_cand = 0;
        m_run = 0; m_none = 0; m_rep = 0;
    endtask

    task automatic model_frame(input logic [15:0] mask);
        int n;
        int c;
        n = $countones(mask);
        c = 0;
        for (int i = 15; i >= 0; i--) if (mask[i]) c = i;
        m_pulse = 0;
        if (!m_held) begin
            if (m_run > 0 && n == 1 && c == m_cand) m_run++;
            else if (m_run > 0) m_run = 0;
            else if (n == 1) begin m_run = 1; m_cand = c; end
            if (m_run == DS) begin
                m_pulse = 1; m_held = 1; m_code = m_cand;
                m_run = 0; m_none = 0; m_rep = 0;
            end
        end else if (n == 0) begin
            m_none++;
            m_rep = -1;
            if (m_none == DS) begin m_held = 0; m_none = 0; end
        end else begin
            m_none = 0;
            m_rep++;
`ifdef KEY_REPEAT_EN
            if (m_rep >= 2 * RS && ((m_rep - 2 * RS) % RS) == 0) m_pulse = 1;
`endif
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s frame %0d: got %0h expected %0h", name, frame_no, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rows", int'(rows), 'he);
        chk("reset_code", int'(key_code), 0);
        chk("reset_valid", int'(key_valid), 0);
        chk("reset_held", int'(key_held), 0);
        rst = 1'b0;
        model_reset();
    endtask

    // Called just after the edge that starts cycle 0 of a frame; returns at the same point of the next frame.
    task automatic run_frame(input logic [15:0] mask);
        bit          held_before;
        logic [3:0]  exp_rows;
        held_before = m_held;
        pressed = mask;
        model_frame(mask);
        for (int k = 1; k <= 4 * ST; k++) begin
            exp_rows = ~(4'b0001 << ((k - 1) / ST));
            chk("rows", int'(rows), int'(exp_rows));
            @(posedge clk);
            #1;
            if (k < 4 * ST) begin
                chk("valid_idle", int'(key_valid), 0);
                chk("held_mid", int'(key_held), int'(held_before));
            end else begin
                chk("valid", int'(key_valid), int'(m_pulse));
                chk("held", int'(key_held), int'(m_held));
                chk("code", int'(key_code), m_code);
            end
        end
        frame_no++;
    endtask

    typedef struct {
        logic [15:0] mask;
        logic        v;
        logic        h;
        logic [3:0]  c;
    } vec_t;

    vec_t vec_q[$];

    task automatic add_n(input int n, input logic [15:0] mask, input logic v, input logic h, input logic [3:0] c);
        vec_t e;
        e.mask = mask; e.v = v; e.h = h; e.c = c;
        for (int i = 0; i < n; i++) vec_q.push_back(e);
    endtask

    localparam logic [15:0] K0 = 16'h0001;
    localparam logic [15:0] K3 = 16'h0008;
    localparam logic [15:0] K5 = 16'h0020;
    localparam logic [15:0] K9 = 16'h0200;

    initial begin
        logic [15:0] cur;
        rst = 1'b1;
        pressed = 16'h0;

        // Hold, partial release, full release.
        add_n(2, K9, 0, 0, 0);
        add_n(1, K9, 1, 1, 9);
        add_n(2, K9, 0, 1, 9);
        add_n(2, 0, 0, 1, 9);
        add_n(1, K9, 0, 1, 9);
        add_n(2, 0, 0, 1, 9);
        add_n(2, 0, 0, 0, 9);
        // Bounce never reaches acceptance.
        add_n(2, K9, 0, 0, 9);
        add_n(1, 0, 0, 0, 9);
        add_n(2, K9, 0, 0, 9);
        add_n(1, 0, 0, 0, 9);
        // Two keys together are rejected; the survivor is accepted.
        add_n(10, K0 | K5, 0, 0, 9);
        add_n(2, K0, 0, 0, 9);
        add_n(1, K0, 1, 1, 0);
        add_n(2, 0, 0, 1, 0);
        add_n(1, 0, 0, 0, 0);
        // Candidate switch restarts acquisition; extra key while pressed is ignored.
        add_n(1, K9, 0, 0, 0);
        add_n(3, K3, 0, 0, 0);
        add_n(1, K3, 1, 1, 3);
        add_n(1, K3 | K9, 0, 1, 3);
        add_n(2, 0, 0, 1, 3);
        add_n(1, 0, 0, 0, 3);

        do_reset();
        foreach (vec_q[i]) begin
            run_frame(vec_q[i].mask);
            chk("tbl_valid", int'(key_valid), int'(vec_q[i].v));
            chk("tbl_held", int'(key_held), int'(vec_q[i].h));
            chk("tbl_code", int'(key_code), int'(vec_q[i].c));
        end

        // Reset while a key is pressed, key kept down: re-acquired from scratch.
        for (int i = 0; i < 5; i++) run_frame(K9);
        chk("pre_rst_held", int'(key_held), 1);
        do_reset();
        for (int i = 0; i < 12; i++) run_frame(K9);
        chk("post_rst_held", int'(key_held), 1);
        for (int i = 0; i < 3; i++) run_frame(16'h0);

        // Random key activity with a bias towards holding the current mask.
        cur = 16'h0;
        for (int i = 0; i < 60; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r >= 5 && r <= 6) cur = 16'h0;
            else if (r >= 7 && r <= 8) cur = 16'h1 << $urandom_range(0, 15);
            else if (r == 9) cur = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            run_frame(cur);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the 4-digit multiplexed 7-segment display driver.
- Drives a 4x4 matrix keypad (floor-call / cabin buttons) one row at a time, active-low, and samples the column lines.
- Debounces the sampled keys and delivers one validated key code per press to the elevator control logic as a one-cycle pulse plus a held level.

Parameters:
- SCAN_TICKS, 12500, clk cycles each row is driven before its columns are sampled; must be >= 4.
- DEBOUNCE_SCANS, 3, consecutive identical full frames needed to accept a press or a release; must be >= 1.
- REPEAT_SCANS, 20, auto-repeat period in frames; used only with KEY_REPEAT_EN.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous reset, active-high.
- cols  input  4  keypad column lines, active-low, asynchronous; bit c = column c.
- rows  output  4  keypad row drive, active-low, exactly one bit low at any time.
- key_code  output  4  code of the last accepted key = row*4 + col.
- key_valid  output  1  one-cycle pulse when key_code is newly accepted.
- key_held  output  1  high while an accepted key is still pressed.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: rows=4'b1110, key_code=0, key_valid=0, key_held=0, tick=0, row_idx=0, FSM=IDLE, counters=0, column synchroniser flops=4'b1111.
- Synchroniser: cols passes through a 2-flop synchroniser. Only the synchronised value is used.
- Tick counter: counts 0..SCAN_TICKS-1 and wraps.
  - At tick==SCAN_TICKS-1, the synchronised cols are sampled for row_idx, then row_idx advances 0->1->2->3->0.
  - rows = ~(1<<row_idx).
- Frame: 4 row samples, i.e. 4*SCAN_TICKS cycles.
  - Frame completes on the row-3 sample cycle.
  - Frame result is NONE (0 keys low), SINGLE(code) (exactly 1 key), or MULTI (2 or more keys).
- FSM evaluates only on frame-completion cycles. Outputs update on the following edge.
  - IDLE:
    - SINGLE(c) -> cand=c, cnt=1. If DEBOUNCE_SCANS==1, accept immediately (see below); else go to DEBOUNCE.
    - NONE or MULTI -> stay.
  - DEBOUNCE:
    - SINGLE(cand) -> cnt++. When cnt reaches DEBOUNCE_SCANS, accept.
    - Anything else -> IDLE, cnt=0.
  - Accept: key_code<=cand, key_valid<=1 for exactly one cycle, key_held<=1, state PRESSED, cnt=0.
  - PRESSED:
    - NONE -> RELEASE, cnt=1. If DEBOUNCE_SCANS==1, go straight to IDLE and clear key_held.
    - SINGLE or MULTI -> stay.
  - RELEASE:
    - NONE -> cnt++. When cnt reaches DEBOUNCE_SCANS -> IDLE, key_held<=0.
    - Anything else -> PRESSED, cnt=0, no new pulse.
- Press latency: key_valid rises 1 cycle after the completion of the DEBOUNCE_SCANS-th consecutive matching frame.
- Multi-key: rejected during acquisition. While PRESSED, an extra key never generates a pulse.
- key_code holds its value after release until the next accept.
- key_valid is never high for 2 consecutive cycles.
- rst asserted mid-operation: everything returns to reset values on the next edge. A still-pressed key is re-acquired from IDLE.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - In PRESSED, a frame counter runs.
  - First repeat pulse after 2*REPEAT_SCANS frames, then one every REPEAT_SCANS frames while the key is held.
  - key_code is unchanged on repeat pulses.
  - The counter clears on entry to PRESSED and on a RELEASE->PRESSED return.
- Undefined: exactly one key_valid pulse per accepted press; no repeat logic is synthesised.

Test Plan:
Bench parameters: SCAN_TICKS=4, DEBOUNCE_SCANS=3, REPEAT_SCANS=2, so 1 frame = 16 cycles.
1. Reset: rst high 3 cycles, cols=4'b1111 -> rows=4'b1110, key_code=0, key_valid=0, key_held=0. Then rows cycles 1110, 1101, 1011, 0111 with 4 cycles each.
2. Hold key row2/col1 (cols=4'b1101 whenever rows==4'b1011) -> single key_valid pulse 1 cycle after the 3rd complete frame; key_code=9, key_held=1; no further pulse while held (macro off).
3. Bounce: key 9 present for 2 frames, absent 1, present 2, then released -> key_valid never asserted, key_held stays 0.
4. Keys 0 and 5 pressed together for 10 frames -> no pulse, key_held=0. Then release key 5 -> key 0 accepted after 3 frames, key_code=0.
5. Release: key 9 accepted, then released for 2 frames and re-pressed -> key_held stays 1, no pulse. Full release for 3 frames -> key_held falls 1 cycle after the 3rd NONE frame.
6. rst pulsed while key 9 is PRESSED, key kept down -> outputs cleared, then a new pulse after 3 frames. With KEY_REPEAT_EN: repeat pulses after 4 frames, then every 2 frames.
